// File: rtl/chan_arb_pkg.sv
// Shared constants and helpers for the channel arbiter/mux.
package chan_arb_pkg;

   localparam logic [1:0] MODE_STATIC = 2'b00;
   localparam logic [1:0] MODE_FIXED  = 2'b01;
   localparam logic [1:0] MODE_RR     = 2'b10;

   // Upper bounds for the flattened channel bus and a single channel slice.
   localparam int unsigned MAX_BUS = 1024;
   localparam int unsigned MAX_W   = 64;

   // Extract channel k (w bits wide) from a flattened bus; caller narrows to its width.
   function automatic logic [MAX_W-1:0] chan_slice(input logic [MAX_BUS-1:0] data,
                                                   input int unsigned        k,
                                                   input int unsigned        w);
      return MAX_W'(data >> (k * w));
   endfunction

endpackage

// File: rtl/chan_arb_mux_rr_pick.sv
// Rotating-start priority encoder: first set req bit at or after start, wrapping.
module rr_pick #(
   parameter  int unsigned N  = 8,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] start,
   output logic [SW-1:0] gnt_idx,
   output logic          gnt_any
);

   logic [SW-1:0] idx;

   // Scan farthest-first so the nearest requester after start wins.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         idx = SW'((32'(start) + 32'(i)) % N);
         if (req[idx]) begin
            gnt_idx = idx;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/chan_arb_mux.sv
// N-channel valid/ready merger with static, fixed-priority and round-robin selection.
module chan_arb_mux
   import chan_arb_pkg::*;
#(
   parameter  int unsigned W  = 3,
   parameter  int unsigned N  = 8,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic [1:0]      mode,
   input  logic [SW-1:0]   sel,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_chan,
   output logic            out_valid,
   input  logic            out_ready
);

   logic [SW-1:0] ptr;
   logic [SW-1:0] start_c;
   logic [SW-1:0] pick_idx_c;
   logic          pick_any_c;
   logic [SW-1:0] gnt_idx_c;
   logic          gnt_any_c;
   logic          free_c;
   logic          sel_ok_c;
   logic [N-1:0]  valid_sh_c;

   assign free_c = ~out_valid | out_ready;

   // Fixed priority is the rotating encoder pinned to start at channel 0.
   assign start_c = (mode == MODE_FIXED) ? '0 : ptr;

   rr_pick #(.N(N)) u_pick (
      .req     (in_valid),
      .start   (start_c),
      .gnt_idx (pick_idx_c),
      .gnt_any (pick_any_c)
   );

   assign sel_ok_c   = (32'(sel) < N);
   assign valid_sh_c = in_valid >> sel;

   // Candidate selection by mode; 2'b11 falls through to round-robin.
   always_comb begin
      gnt_idx_c = '0;
      gnt_any_c = 1'b0;
      case (mode)
         MODE_STATIC: begin
            gnt_idx_c = sel;
            gnt_any_c = sel_ok_c & valid_sh_c[0];
         end
         default: begin
            gnt_idx_c = pick_idx_c;
            gnt_any_c = pick_any_c;
         end
      endcase
   end

   always_comb begin
      in_ready = '0;
      if (gnt_any_c) in_ready[gnt_idx_c] = free_c;
   end

   // Round-robin pointer advances past the channel just accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (mode[1] && gnt_any_c && free_c) begin
         ptr <= (32'(gnt_idx_c) == N - 1) ? '0 : gnt_idx_c + SW'(1);
      end
   end

   // Output register: reload whenever the slot is free, hold under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (free_c) begin
         if (gnt_any_c) begin
            out_valid <= 1'b1;
            out_data  <= W'(chan_slice(MAX_BUS'(in_data), 32'(gnt_idx_c), W));
            out_chan  <= gnt_idx_c;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_chan_arb_mux.sv
// Directed self-checking bench for chan_arb_mux (N=8/W=3 and N=3/W=16 instances).
module tb_chan_arb_mux;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // N=8, W=3 instance
   logic [23:0] in_data8;
   logic [7:0]  in_valid8, in_ready8;
   logic [1:0]  mode8;
   logic [2:0]  sel8, out_data8, out_chan8;
   logic        out_valid8, out_ready8;

   // N=3, W=16 instance
   logic [47:0] in_data3;
   logic [2:0]  in_valid3, in_ready3;
   logic [1:0]  mode3, sel3, out_chan3;
   logic [15:0] out_data3;
   logic        out_valid3, out_ready3;

   int vecs = 0;
   int errs = 0;

   chan_arb_mux #(.W(3), .N(8)) dut8 (
      .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
      .mode(mode8), .sel(sel8), .out_data(out_data8), .out_chan(out_chan8),
      .out_valid(out_valid8), .out_ready(out_ready8));

   chan_arb_mux #(.W(16), .N(3)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
      .out_valid(out_valid3), .out_ready(out_ready3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] rr8_exp [5] = '{3'd0, 3'd3, 3'd7, 3'd0, 3'd3};
   logic [1:0] rr3_exp [4] = '{2'd0, 2'd2, 2'd0, 2'd2};

   initial begin
      for (int k = 0; k < 8; k++) in_data8[k*3 +: 3] = 3'(k);
      for (int k = 0; k < 3; k++) in_data3[k*16 +: 16] = 16'hA000 + 16'(k);

      // Reset with every channel valid
      rst = 1'b1; mode8 = 2'b00; sel8 = 3'd5; in_valid8 = 8'hFF; out_ready8 = 1'b1;
      mode3 = 2'b00; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;
      tick(); tick();
      chk("rst_valid", 32'(out_valid8), 32'd0);
      chk("rst_data",  32'(out_data8),  32'd0);
      chk("rst_chan",  32'(out_chan8),  32'd0);
      chk("rst_valid3", 32'(out_valid3), 32'd0);

      // Static select of channel 5
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("static_ready", 32'(in_ready8), 32'h20);
         tick();
         chk("static_valid", 32'(out_valid8), 32'd1);
         chk("static_data",  32'(out_data8),  32'd5);
         chk("static_chan",  32'(out_chan8),  32'd5);
      end
      in_valid8 = 8'hDF;
      #1;
      chk("static_drop_ready", 32'(in_ready8), 32'h00);
      tick();
      chk("static_drop_valid", 32'(out_valid8), 32'd0);

      // Fixed priority: lowest valid channel (2) always wins
      mode8 = 2'b01; in_valid8 = 8'b1010_0100;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("fixed_ready", 32'(in_ready8), 32'h04);
         tick();
         chk("fixed_valid", 32'(out_valid8), 32'd1);
         chk("fixed_chan",  32'(out_chan8),  32'd2);
         chk("fixed_data",  32'(out_data8),  32'd2);
      end

      // Round-robin from reset on both instances
      rst = 1'b1; mode8 = 2'b10; in_valid8 = 8'b1000_1001;
      mode3 = 2'b10; in_valid3 = 3'b101;
      tick();
      rst = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("rr_ready", 32'(in_ready8), 32'(8'(1) << rr8_exp[i]));
         if (i < 4) chk("rr3_ready", 32'(in_ready3), 32'(3'(1) << rr3_exp[i]));
         tick();
         chk("rr_chan", 32'(out_chan8), 32'(rr8_exp[i]));
         chk("rr_data", 32'(out_data8), 32'(rr8_exp[i]));
         if (i < 4) begin
            chk("rr3_chan", 32'(out_chan3), 32'(rr3_exp[i]));
            chk("rr3_data", 32'(out_data3), 32'h0000A000 + 32'(rr3_exp[i]));
         end
      end

      // Backpressure during round-robin with all channels valid; N=3 static with sel out of range
      rst = 1'b1; in_valid8 = 8'hFF;
      tick();
      rst = 1'b0;
      mode3 = 2'b00; sel3 = 2'd3; in_valid3 = 3'b111;
      #1;
      chk("sel_oor_ready3", 32'(in_ready3), 32'd0);
      tick();
      chk("sel_oor_valid3", 32'(out_valid3), 32'd0);
      chk("bp_chan0", 32'(out_chan8), 32'd0);
      tick();
      chk("bp_chan1", 32'(out_chan8), 32'd1);
      tick();
      chk("bp_chan2", 32'(out_chan8), 32'd2);
      out_ready8 = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_ready", 32'(in_ready8), 32'h00);
         tick();
         chk("bp_hold_valid", 32'(out_valid8), 32'd1);
         chk("bp_hold_chan",  32'(out_chan8),  32'd2);
         chk("bp_hold_data",  32'(out_data8),  32'd2);
      end
      chk("sel_oor_hold3", 32'(out_valid3), 32'd0);
      out_ready8 = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready8), 32'h08);
      tick();
      chk("bp_release_valid", 32'(out_valid8), 32'd1);
      chk("bp_release_chan",  32'(out_chan8),  32'd3);
      chk("bp_release_data",  32'(out_data8),  32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
